// File: rtl/strobe_div_pkg.sv
// Shared constants, helpers and types for the programmable strobe divider.
package strobe_div_pkg;

    localparam int DIV_MIN = 2;

    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        WR_OK      = 2'd0,
        WR_BAD_DIV = 2'd1,
        WR_BAD_CH  = 2'd2
    } wr_status_e;

endpackage

// File: rtl/strobe_div_chan.sv
// One strobe channel: counter, double-buffered divisor and period-boundary apply.
// STROBE_DIV_PROG_STATUS_EN exposes the pending flag as pending_o.
module strobe_div_chan
    import strobe_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_div_i,
    output logic             strobe_o
`ifdef STROBE_DIV_PROG_STATUS_EN
    ,
    output logic             pending_o
`endif
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             term_s;
    logic             apply_s;

    // active never drops below 2, so the subtraction cannot wrap
    assign term_s   = (cnt_q == (active_q - WIDTH'(1)));
    assign apply_s  = (en_i && term_s) || !en_i || sync_i;
    assign strobe_o = term_s;

    // Next-state for counter, divisor buffers and pending flag
    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        if (sync_i || !en_i || term_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        if (apply_s) begin
            // a write landing on the apply edge bypasses the shadow
            if (wr_i) begin
                active_d = wr_div_i;
                shadow_d = wr_div_i;
            end else begin
                active_d = shadow_q;
                shadow_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (wr_i) begin
            shadow_d  = wr_div_i;
            pending_d = 1'b1;
        end else begin
            shadow_d  = shadow_q;
            pending_d = pending_q;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            active_q  <= DEF_DIV;
            shadow_q  <= DEF_DIV;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

`ifdef STROBE_DIV_PROG_STATUS_EN
    assign pending_o = pending_q;
`endif

`ifdef FORMAL
    // Structural invariants of a single channel
    always_comb begin
        if (rst_ni) begin
            assert (cnt_q < active_q);
            assert (strobe_o == (cnt_q == (active_q - WIDTH'(1))));
            if (pending_q && !pending_d) begin
                assert (apply_s);
            end else begin
                assert (1'b1);
            end
        end else begin
            assert (1'b1);
        end
    end
`endif

endmodule

// File: rtl/strobe_div_prog.sv
// Multi-channel runtime-programmable strobe generator: write validation/decode and channel array.
// STROBE_DIV_PROG_STATUS_EN adds o_pending, the per-channel pending flags.
module strobe_div_prog
    import strobe_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NUM_CH-1:0] i_en,
    input  logic              i_sync,
    input  logic              i_wr_valid,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [WIDTH-1:0]  i_wr_div,
    output logic              o_wr_err,
    output logic [NUM_CH-1:0] o_strobe
`ifdef STROBE_DIV_PROG_STATUS_EN
    ,
    output logic [NUM_CH-1:0] o_pending
`endif
);

    if ((DEFAULT_DIV < DIV_MIN) ||
        (longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - longint'(1)))) begin : g_bad_default
        $error("strobe_div_prog: DEFAULT_DIV out of range");
    end

    localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);

    wr_status_e        status_s;
    logic [NUM_CH-1:0] wr_dec_s;
    logic              wr_err_q, wr_err_d;

    // Classify the incoming write
    always_comb begin
        if (i_wr_div < WIDTH'(DIV_MIN)) begin
            status_s = WR_BAD_DIV;
        end else if ({1'b0, i_wr_ch} >= NUM_CH_W) begin
            status_s = WR_BAD_CH;
        end else begin
            status_s = WR_OK;
        end
    end

    // One-hot channel select for accepted writes only
    always_comb begin
        wr_dec_s = '0;
        if (i_wr_valid && (status_s == WR_OK)) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_dec_s[c] = (i_wr_ch == CH_W'(c));
            end
        end else begin
            wr_dec_s = '0;
        end
    end

    assign wr_err_d = i_wr_valid && (status_s != WR_OK);

    // Rejection pulse, visible the cycle after the bad write
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign o_wr_err = wr_err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        strobe_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i     (i_clk),
            .rst_ni    (i_reset_n),
            .en_i      (i_en[c]),
            .sync_i    (i_sync),
            .wr_i      (wr_dec_s[c]),
            .wr_div_i  (i_wr_div),
            .strobe_o  (o_strobe[c])
`ifdef STROBE_DIV_PROG_STATUS_EN
            ,
            .pending_o (o_pending[c])
`endif
        );
    end

`ifdef FORMAL
    // Only validated writes ever reach a channel, and at most one at a time
    always_comb begin
        if (i_reset_n && (wr_dec_s != '0)) begin
            assert (status_s == WR_OK);
            assert ($onehot0(wr_dec_s));
        end else begin
            assert (1'b1);
        end
    end
`endif

endmodule

// File: tb/tb_strobe_div_prog.sv
// Directed self-checking bench for strobe_div_prog (five channels so a bad channel index is reachable).
module tb_strobe_div_prog;

    localparam int NCH = 5;
    localparam int W   = 16;
    localparam int DEF = 10;
    localparam int CHW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           sync;
    logic           wr_valid;
    logic [CHW-1:0] wr_ch;
    logic [W-1:0]   wr_div;
    logic           wr_err;
    logic [NCH-1:0] strobe;
`ifdef STROBE_DIV_PROG_STATUS_EN
    logic [NCH-1:0] pend;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    strobe_div_prog #(
        .NUM_CH      (NCH),
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_en       (en),
        .i_sync     (sync),
        .i_wr_valid (wr_valid),
        .i_wr_ch    (wr_ch),
        .i_wr_div   (wr_div),
        .o_wr_err   (wr_err),
        .o_strobe   (strobe)
`ifdef STROBE_DIV_PROG_STATUS_EN
        ,
        .o_pending  (pend)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_div(input logic [CHW-1:0] ch, input logic [W-1:0] d);
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_div   = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = '0; sync = 1'b0;
        wr_valid = 1'b0; wr_ch = '0; wr_div = '0;
        tick(); tick(); tick();
        checks++;
        if (strobe !== 5'b00000) begin
            errors++; $display("FAIL reset_strobe got=%b exp=%b", strobe, 5'b00000);
        end
        checks++;
        if (wr_err !== 1'b0) begin
            errors++; $display("FAIL reset_wr_err got=%b exp=%b", wr_err, 1'b0);
        end
`ifdef STROBE_DIV_PROG_STATUS_EN
        checks++;
        if (pend !== 5'b00000) begin
            errors++; $display("FAIL reset_pending got=%b exp=%b", pend, 5'b00000);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [NCH-1:0] exp;
        en = 5'b00001;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = ((k % 10) == 9) ? 5'b00001 : 5'b00000;
            checks++;
            if (strobe !== exp) begin
                errors++; $display("FAIL basic k=%0d got=%b exp=%b", k, strobe, exp);
            end
        end
    endtask

    task automatic test_shrink;
        logic [NCH-1:0] exp;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp = ((k == 9) || ((k > 9) && (((k - 9) % 3) == 0))) ? 5'b00001 : 5'b00000;
            checks++;
            if (strobe !== exp) begin
                errors++; $display("FAIL shrink k=%0d got=%b exp=%b", k, strobe, exp);
            end
`ifdef STROBE_DIV_PROG_STATUS_EN
            checks++;
            if (pend[0] !== ((k >= 5) && (k <= 9))) begin
                errors++; $display("FAIL shrink_pending k=%0d got=%b exp=%b", k, pend[0], ((k >= 5) && (k <= 9)));
            end
`endif
            if (k == 4) begin
                wr_valid = 1'b1; wr_ch = 3'd0; wr_div = 16'd3;
            end else begin
                wr_valid = 1'b0;
            end
        end
    endtask

    task automatic test_wr_err;
        logic [NCH-1:0] exp;
        wr_valid = 1'b1; wr_ch = 3'd1; wr_div = 16'd1;
        tick();
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL wr_err_bad_div got=%b exp=%b", wr_err, 1'b1);
        end
        wr_ch = 3'd5; wr_div = 16'd4;
        tick();
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL wr_err_bad_ch got=%b exp=%b", wr_err, 1'b1);
        end
        wr_valid = 1'b0;
        tick();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++; $display("FAIL wr_err_clear got=%b exp=%b", wr_err, 1'b0);
        end
`ifdef STROBE_DIV_PROG_STATUS_EN
        checks++;
        if (pend !== 5'b00000) begin
            errors++; $display("FAIL wr_err_pending got=%b exp=%b", pend, 5'b00000);
        end
`endif
        en = 5'b00010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = ((k % 10) == 9) ? 5'b00010 : 5'b00000;
            checks++;
            if (strobe !== exp) begin
                errors++; $display("FAIL wr_err_ch1_period k=%0d got=%b exp=%b", k, strobe, exp);
            end
        end
    endtask

    task automatic test_sync;
        logic [NCH-1:0] exp;
        int d;
        en = 5'b00000;
        tick();
        write_div(3'd0, 16'd4);
        write_div(3'd1, 16'd5);
        write_div(3'd2, 16'd6);
        write_div(3'd3, 16'd7);
        en = 5'b00001; tick(); tick(); tick();
        en = 5'b00011; tick(); tick();
        en = 5'b01111; tick(); tick(); tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        checks++;
        if (strobe !== 5'b00000) begin
            errors++; $display("FAIL sync_zero got=%b exp=%b", strobe, 5'b00000);
        end
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp = '0;
            for (int c = 0; c < 4; c++) begin
                d = 4 + c;
                exp[c] = ((k % d) == (d - 1));
            end
            checks++;
            if (strobe !== exp) begin
                errors++; $display("FAIL sync_phase k=%0d got=%b exp=%b", k, strobe, exp);
            end
        end
    endtask

    task automatic test_bypass;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = strobe[2];
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL bypass_wait got=%b exp=%b", found, 1'b1);
        end
        write_div(3'd2, 16'd5);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (strobe[2] !== ((k % 5) == 4)) begin
                errors++; $display("FAIL bypass_period k=%0d got=%b exp=%b", k, strobe[2], ((k % 5) == 4));
            end
`ifdef STROBE_DIV_PROG_STATUS_EN
            checks++;
            if (pend[2] !== 1'b0) begin
                errors++; $display("FAIL bypass_pending k=%0d got=%b exp=%b", k, pend[2], 1'b0);
            end
`endif
        end
        en[2] = 1'b0;
        tick();
        write_div(3'd2, 16'd3);
`ifdef STROBE_DIV_PROG_STATUS_EN
        checks++;
        if (pend[2] !== 1'b0) begin
            errors++; $display("FAIL disabled_pending got=%b exp=%b", pend[2], 1'b0);
        end
`endif
        en[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (strobe[2] !== ((k % 3) == 2)) begin
                errors++; $display("FAIL disabled_apply k=%0d got=%b exp=%b", k, strobe[2], ((k % 3) == 2));
            end
        end
    endtask

    task automatic test_async_reset;
        logic found;
        logic [NCH-1:0] exp;
        en = 5'b00001;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = strobe[0];
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL areset_wait got=%b exp=%b", found, 1'b1);
        end
        tick();
        write_div(3'd0, 16'd7);
`ifdef STROBE_DIV_PROG_STATUS_EN
        checks++;
        if (pend[0] !== 1'b1) begin
            errors++; $display("FAIL areset_pending_set got=%b exp=%b", pend[0], 1'b1);
        end
`endif
        tick();
        tick();
        checks++;
        if (strobe !== 5'b00001) begin
            errors++; $display("FAIL areset_pre_strobe got=%b exp=%b", strobe, 5'b00001);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (strobe !== 5'b00000) begin
            errors++; $display("FAIL areset_strobe got=%b exp=%b", strobe, 5'b00000);
        end
`ifdef STROBE_DIV_PROG_STATUS_EN
        checks++;
        if (pend !== 5'b00000) begin
            errors++; $display("FAIL areset_pending got=%b exp=%b", pend, 5'b00000);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = ((k % 10) == 9) ? 5'b00001 : 5'b00000;
            checks++;
            if (strobe !== exp) begin
                errors++; $display("FAIL areset_period k=%0d got=%b exp=%b", k, strobe, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shrink();
        test_wr_err();
        test_sync();
        test_bypass();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
